ptw_mem_bridge: RTL

PTW_MEM_BRIDGE -- requirements
Module: ptw_mem_bridge

---
 rtl/ptw_mem_bridge.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ptw_mem_bridge.sv
// Bridges two page-table-walker read ports (I-MMU, D-MMU) onto a single Wishbone
// read master: round-robin grant, one outstanding read, error/timeout folded into zero data.
module ptw_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ptw0_req,
  input  logic [31:0] ptw0_addr,
  output logic [31:0] ptw0_data,
  output logic        ptw0_ack,

  input  logic        ptw1_req,
  input  logic [31:0] ptw1_addr,
  output logic [31:0] ptw1_data,
  output logic        ptw1_ack,

  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,

  output logic        bus_fault_o
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_grant;
  logic                r_last_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_adr;
  logic                r_cyc;
  logic                r_stb;
  logic                r_ack0;
  logic                r_ack1;
  logic [DATA_W-1:0]   r_data0;
  logic [DATA_W-1:0]   r_data1;
  logic                r_fault;

  logic                w_any_req;
  logic                w_grant_sel;
  logic [ADDR_W-1:0]   w_req_addr;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_timeout;
  logic                w_bus_done;
  logic                w_bus_fail;
  logic                w_granted_req;
  logic [DATA_W-1:0]   w_rd_data;

  // Arbitration and bus-completion decode
  always_comb begin
    w_any_req     = ptw0_req | ptw1_req;
    w_grant_sel   = (ptw0_req & ptw1_req) ? ~r_last_grant : ptw1_req;
    w_req_addr    = w_grant_sel ? ptw1_addr : ptw0_addr;
    w_cnt_inc     = r_cnt + CNT_W'(1);
    w_timeout     = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    w_bus_done    = wb_err_i | wb_ack_i | w_timeout;
    w_bus_fail    = wb_err_i | ~wb_ack_i;
    w_granted_req = r_grant ? ptw1_req : ptw0_req;
    w_rd_data     = (wb_ack_i & ~wb_err_i) ? wb_dat_i : DATA_W'(0);
  end

  // Walk-read FSM; acks and data are one-cycle registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= CNT_W'(0);
      r_adr        <= ADDR_W'(0);
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_data0      <= DATA_W'(0);
      r_data1      <= DATA_W'(0);
      r_fault      <= 1'b0;
    end else begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_data0 <= DATA_W'(0);
      r_data1 <= DATA_W'(0);
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_grant_sel;
            r_last_grant <= w_grant_sel;
            r_adr        <= w_req_addr & ~ADDR_W'(3);
            r_cyc        <= 1'b1;
            r_stb        <= 1'b1;
            r_cnt        <= CNT_W'(0);
            r_state      <= S_BUS;
          end
        end
        S_BUS: begin
          if (w_bus_done) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_fault <= w_bus_fail;
            r_state <= S_RESP;
            // A requester that withdrew (flush) gets nothing back
            if (w_granted_req) begin
              if (r_grant) begin
                r_ack1  <= 1'b1;
                r_data1 <= w_rd_data;
              end else begin
                r_ack0  <= 1'b1;
                r_data0 <= w_rd_data;
              end
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ptw0_ack    = r_ack0;
  assign ptw0_data   = r_data0;
  assign ptw1_ack    = r_ack1;
  assign ptw1_data   = r_data1;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_stb;
  assign wb_we_o     = 1'b0;
  assign wb_sel_o    = {SEL_W{1'b1}};
  assign wb_adr_o    = r_adr;
  assign bus_fault_o = r_fault;

endmodule
